accel_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the accelerator's single memory access port (512-bit read, 32-bit write) among `NUM_CORES` hashing cores. Each core drives its own level-held read/write request, and the arbiter serializes them into one outstanding memory transaction at a time. It routes each completion back to the requester and advances a fairness pointer. It sits between the per-core `mem_acc_*` ports and the memory controller.

---
 rtl/accel_mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_accel_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : accel_mem_arbiter
// Description : Round-robin arbiter sharing one memory access port
//               (512-bit read, 32-bit write) among NUM_CORES hashing cores.
//               A single transaction is outstanding at a time.
//
//               The winning core's address and data are latched at grant.
//               The transaction is held on the memory port until its
//               completion pulse arrives. The completion is then routed
//               back to the granted core, and a one-cycle RELEASE gap lets
//               that core drop its level request.
//
// Ports       : clk, rst                 - clock, asynchronous active-high reset
//               core_read_en/_addr       - per-core level read requests
//               core_write_en/_addr/_data- per-core level write requests
//               core_read_data           - memory read data broadcast
//               core_read_data_valid     - one-hot read completion
//               core_write_done          - one-hot write completion
//               mem_acc_read_*           - memory read request / response
//               mem_acc_write_*          - memory write request / response
//               grant_id                 - owner of the current transaction
//               busy                     - transaction outstanding
//               unexpected_resp          - sticky stray-completion flag
// Revision    : 1.0 - initial release
// ============================================================================
module accel_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_CORES-1:0]          core_read_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_read_addr,
    input  logic [NUM_CORES-1:0]          core_write_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_write_addr,
    input  logic [NUM_CORES*32-1:0]       core_write_data,

    output logic [511:0]                  core_read_data,
    output logic [NUM_CORES-1:0]          core_read_data_valid,
    output logic [NUM_CORES-1:0]          core_write_done,

    output logic                          mem_acc_read_en,
    output logic [ADDR_W-1:0]             mem_acc_read_addr,
    output logic                          mem_acc_write_en,
    output logic [ADDR_W-1:0]             mem_acc_write_addr,
    output logic [31:0]                   mem_acc_write_data,
    input  logic [511:0]                  mem_acc_read_data,
    input  logic                          mem_acc_read_data_valid,
    input  logic                          mem_acc_write_done,

    output logic [$clog2(NUM_CORES)-1:0]  grant_id,
    output logic                          busy,
    output logic                          unexpected_resp
);

    localparam int c_id_w   = $clog2(NUM_CORES);
    // One extra bit so ptr + offset (< 2*NUM_CORES) cannot overflow
    // before the wrap correction.
    localparam int c_scan_w = c_id_w + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [c_id_w-1:0]   r_rr_ptr;
    logic [c_id_w-1:0]   r_grant_id;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_unexpected;

    logic                w_found;
    logic [c_id_w-1:0]   w_winner;
    logic [c_scan_w-1:0] w_scan;
    logic [c_id_w-1:0]   w_next_ptr;
    logic                w_win_write;
    logic [ADDR_W-1:0]   w_sel_rd_addr;
    logic [ADDR_W-1:0]   w_sel_wr_addr;
    logic [31:0]         w_sel_wr_data;
    logic                w_grant;
    logic                w_stray;
    logic [NUM_CORES-1:0] w_grant_onehot;

    // ------------------------------------------------------------------
    // Round-robin scan: first requester at or after r_rr_ptr wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_scan = {1'b0, r_rr_ptr} + c_scan_w'(i);
            if (w_scan >= c_scan_w'(NUM_CORES)) begin
                w_scan = w_scan - c_scan_w'(NUM_CORES);
            end
            if (!w_found &&
                (core_read_en[w_scan[c_id_w-1:0]] | core_write_en[w_scan[c_id_w-1:0]])) begin
                w_found  = 1'b1;
                w_winner = w_scan[c_id_w-1:0];
            end
        end
    end

    // Operand mux for the winning core; constant slice indices only.
    always_comb begin
        w_win_write   = 1'b0;
        w_sel_rd_addr = '0;
        w_sel_wr_addr = '0;
        w_sel_wr_data = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (w_winner == c_id_w'(k)) begin
                w_win_write   = core_write_en[k];
                w_sel_rd_addr = core_read_addr[k*ADDR_W +: ADDR_W];
                w_sel_wr_addr = core_write_addr[k*ADDR_W +: ADDR_W];
                w_sel_wr_data = core_write_data[k*32 +: 32];
            end
        end
    end

    assign w_next_ptr = (w_winner == c_id_w'(NUM_CORES - 1)) ? '0 : w_winner + 1'b1;
    assign w_grant    = (r_state == ST_IDLE) && w_found;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = w_win_write ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (mem_acc_read_data_valid) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_WRITE: begin
                if (mem_acc_write_done) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // A completion that does not match the current transaction type.
    assign w_stray = (mem_acc_read_data_valid && (r_state != ST_READ)) ||
                     (mem_acc_write_done      && (r_state != ST_WRITE));

    // ------------------------------------------------------------------
    // State and grant registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_unexpected <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_grant_id <= w_winner;
                r_rr_ptr   <= w_next_ptr;
                if (w_win_write) begin
                    r_wr_addr <= w_sel_wr_addr;
                    r_wr_data <= w_sel_wr_data;
                end else begin
                    r_rd_addr <= w_sel_rd_addr;
                end
            end
            if (w_stray) begin
                r_unexpected <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: enables decode from the state register so an asynchronous
    // reset drops them immediately; completions pass through combinationally.
    // ------------------------------------------------------------------
    assign w_grant_onehot = NUM_CORES'(1) << r_grant_id;

    assign mem_acc_read_en    = (r_state == ST_READ);
    assign mem_acc_write_en   = (r_state == ST_WRITE);
    assign mem_acc_read_addr  = r_rd_addr;
    assign mem_acc_write_addr = r_wr_addr;
    assign mem_acc_write_data = r_wr_data;

    assign core_read_data       = mem_acc_read_data;
    assign core_read_data_valid = ((r_state == ST_READ) && mem_acc_read_data_valid) ?
                                  w_grant_onehot : '0;
    assign core_write_done      = ((r_state == ST_WRITE) && mem_acc_write_done) ?
                                  w_grant_onehot : '0;

    assign grant_id        = r_grant_id;
    assign busy            = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign unexpected_resp = r_unexpected;

endmodule
`default_nettype wire

// File: tb/tb_accel_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_mem_arbiter
// Description : Self-checking bench for accel_mem_arbiter. Directed steps
//               followed by randomized requests. Expected grants come from a
//               simple round-robin pick over the currently requesting cores.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      core_read_en;
    logic [N*AW-1:0]   core_read_addr;
    logic [N-1:0]      core_write_en;
    logic [N*AW-1:0]   core_write_addr;
    logic [N*32-1:0]   core_write_data;
    logic [511:0]      core_read_data;
    logic [N-1:0]      core_read_data_valid;
    logic [N-1:0]      core_write_done;
    logic              mem_acc_read_en;
    logic [AW-1:0]     mem_acc_read_addr;
    logic              mem_acc_write_en;
    logic [AW-1:0]     mem_acc_write_addr;
    logic [31:0]       mem_acc_write_data;
    logic [511:0]      mem_acc_read_data;
    logic              mem_acc_read_data_valid;
    logic              mem_acc_write_done;
    logic [1:0]        grant_id;
    logic              busy;
    logic              unexpected_resp;

    accel_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .core_read_en            (core_read_en),
        .core_read_addr          (core_read_addr),
        .core_write_en           (core_write_en),
        .core_write_addr         (core_write_addr),
        .core_write_data         (core_write_data),
        .core_read_data          (core_read_data),
        .core_read_data_valid    (core_read_data_valid),
        .core_write_done         (core_write_done),
        .mem_acc_read_en         (mem_acc_read_en),
        .mem_acc_read_addr       (mem_acc_read_addr),
        .mem_acc_write_en        (mem_acc_write_en),
        .mem_acc_write_addr      (mem_acc_write_addr),
        .mem_acc_write_data      (mem_acc_write_data),
        .mem_acc_read_data       (mem_acc_read_data),
        .mem_acc_read_data_valid (mem_acc_read_data_valid),
        .mem_acc_write_done      (mem_acc_write_done),
        .grant_id                (grant_id),
        .busy                    (busy),
        .unexpected_resp         (unexpected_resp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_ptr   = 0;    // model fairness pointer
    int g_cyc   = 0;    // cycle of the most recent grant

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference pick: first requesting core scanning up from the pointer.
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (core_read_en[c] || core_write_en[c]) return c;
        end
        return -1;
    endfunction

    // Arbitration edge, hold phase, completion, RELEASE, back to IDLE.
    task automatic serve(input int wait_cyc, input bit drop, input string tag);
        int             c;
        bit             is_wr;
        logic [AW-1:0]  ea;
        logic [31:0]    ed;
        logic [511:0]   rd;
        logic [N-1:0]   oh;
        c = model_pick();
        if (c < 0) begin
            $display("FAIL %s: bench issued a grant step with no requests", tag);
            $fatal(1);
        end
        is_wr = core_write_en[c];
        ea    = is_wr ? core_write_addr[c*AW +: AW] : core_read_addr[c*AW +: AW];
        ed    = core_write_data[c*32 +: 32];
        oh    = N'(1) << c;
        m_ptr = (c + 1) % N;
        tick();
        g_cyc = cyc;
        chk({tag, "_grant_id"}, grant_id, c);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_wr_en"}, mem_acc_write_en, is_wr);
        chk({tag, "_rd_en"}, mem_acc_read_en, !is_wr);
        if (is_wr) begin
            chk({tag, "_wr_addr"}, mem_acc_write_addr, ea);
            chk({tag, "_wr_data"}, mem_acc_write_data, ed);
        end else begin
            chk({tag, "_rd_addr"}, mem_acc_read_addr, ea);
        end
        // Scramble the winner's operands; the latched values must hold.
        core_read_addr[c*AW +: AW]  = AW'($urandom);
        core_write_addr[c*AW +: AW] = AW'($urandom);
        core_write_data[c*32 +: 32] = $urandom;
        repeat (wait_cyc) begin
            tick();
            chk({tag, "_hold_en"}, is_wr ? mem_acc_write_en : mem_acc_read_en, 1'b1);
            chk({tag, "_hold_addr"}, is_wr ? mem_acc_write_addr : mem_acc_read_addr, ea);
            chk({tag, "_hold_done"}, {core_read_data_valid, core_write_done}, '0);
        end
        rd = rand512();
        if (is_wr) begin
            mem_acc_write_done = 1'b1;
        end else begin
            mem_acc_read_data       = rd;
            mem_acc_read_data_valid = 1'b1;
        end
        #1;
        chk({tag, "_rd_valid"}, core_read_data_valid, is_wr ? N'(0) : oh);
        chk({tag, "_wr_done"}, core_write_done, is_wr ? oh : N'(0));
        if (!is_wr) chk({tag, "_rd_data"}, core_read_data, rd);
        tick();
        mem_acc_write_done      = 1'b0;
        mem_acc_read_data_valid = 1'b0;
        if (drop) begin
            if (is_wr) core_write_en[c] = 1'b0;
            else       core_read_en[c]  = 1'b0;
        end
        #1;
        chk({tag, "_release_en"}, {mem_acc_read_en, mem_acc_write_en, busy}, 3'b000);
        chk({tag, "_release_done"}, {core_read_data_valid, core_write_done}, '0);
        tick();
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_unexp", unexpected_resp, 1'b0);
        chk("rst_en", {mem_acc_read_en, mem_acc_write_en, busy}, 3'b000);
        tick();
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        int prev;
        rst                     = 1'b1;
        core_read_en            = '0;
        core_write_en           = '0;
        core_read_addr          = '0;
        core_write_addr         = '0;
        core_write_data         = '0;
        mem_acc_read_data       = '0;
        mem_acc_read_data_valid = 1'b0;
        mem_acc_write_done      = 1'b0;

        // Reset values
        tick();
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_unexpected", unexpected_resp, 1'b0);
        chk("rst_rd_en", mem_acc_read_en, 1'b0);
        chk("rst_wr_en", mem_acc_write_en, 1'b0);
        chk("rst_rd_addr", mem_acc_read_addr, '0);
        chk("rst_wr_addr", mem_acc_write_addr, '0);
        chk("rst_wr_data", mem_acc_write_data, '0);
        chk("rst_completions", {core_read_data_valid, core_write_done}, '0);
        tick();
        rst = 1'b0;

        // Single read: core 2 at 0x0040 with three memory wait cycles
        core_read_addr[2*AW +: AW] = 16'h0040;
        core_read_en[2]            = 1'b1;
        serve(3, 1'b1, "single_rd");

        // Core 3 read address changes mid-transaction
        core_read_addr[3*AW +: AW] = 16'h1234;
        core_read_en[3]            = 1'b1;
        serve(2, 1'b1, "latch_rd");

        // Stray read completion in IDLE
        mem_acc_read_data_valid = 1'b1;
        #1;
        chk("stray_no_route", core_read_data_valid, 4'b0000);
        tick();
        mem_acc_read_data_valid = 1'b0;
        chk("stray_flag", unexpected_resp, 1'b1);
        tick();
        tick();
        chk("stray_sticky", unexpected_resp, 1'b1);
        do_reset();

        // Wrong-type completion: write_done during a READ
        core_read_addr[0 +: AW] = 16'h0ABC;
        core_read_en[0]         = 1'b1;
        tick();
        m_ptr = 1;
        chk("wrongtype_rd_en", mem_acc_read_en, 1'b1);
        mem_acc_write_done = 1'b1;
        #1;
        chk("wrongtype_no_route", {core_read_data_valid, core_write_done}, '0);
        tick();
        mem_acc_write_done = 1'b0;
        #1;
        chk("wrongtype_flag", unexpected_resp, 1'b1);
        chk("wrongtype_still_rd", mem_acc_read_en, 1'b1);
        mem_acc_read_data       = rand512();
        mem_acc_read_data_valid = 1'b1;
        #1;
        chk("wrongtype_rd_done", core_read_data_valid, 4'b0001);
        tick();
        mem_acc_read_data_valid = 1'b0;
        core_read_en[0]         = 1'b0;
        tick();
        do_reset();

        // Fairness: all four cores read continuously, zero-wait memory
        core_read_en = 4'b1111;
        prev         = 0;
        for (int i = 0; i < 5; i++) begin
            serve(0, 1'b0, "fair");
            if (i > 0) chk("fair_spacing", g_cyc - prev, 3);
            prev = g_cyc;
        end
        core_read_en = 4'b0000;
        chk("fair_ptr_model", m_ptr, 1);

        // Core 1 read+write together; cores 2, 3, 0 reading
        core_write_addr[1*AW +: AW] = 16'h0010;
        core_write_data[1*32 +: 32] = 32'hDEADBEEF;
        core_write_en[1]            = 1'b1;
        core_read_en                = 4'b1111;
        for (int i = 0; i < 5; i++) serve(1, 1'b1, "rw_prio");

        // Reset during a WRITE wait
        core_write_addr[2*AW +: AW] = 16'h0222;
        core_write_en[2]            = 1'b1;
        tick();
        chk("rstwr_grant", grant_id, 2'd2);
        chk("rstwr_wr_en", mem_acc_write_en, 1'b1);
        core_read_en[0] = 1'b1;
        core_read_en[3] = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("rstwr_en_drop", mem_acc_write_en, 1'b0);
        chk("rstwr_no_done", core_write_done, 4'b0000);
        #3;
        rst   = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) serve(0, 1'b1, "post_rst");

        // Randomized requests against the model
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N; c++) begin
                if (!core_read_en[c] && !core_write_en[c] && ($urandom_range(0, 1) == 1)) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    core_read_addr[c*AW +: AW]  = AW'($urandom);
                    core_write_addr[c*AW +: AW] = AW'($urandom);
                    core_write_data[c*32 +: 32] = $urandom;
                    core_read_en[c]  = (kind != 1);
                    core_write_en[c] = (kind != 0);
                end
            end
            if ((core_read_en | core_write_en) == '0) begin
                core_read_en[$urandom_range(0, N-1)] = 1'b1;
            end
            serve($urandom_range(0, 3), 1'b1, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
